gcd_scheduler: RTL and testbench

- Round-robin arbiter and sequencer that shares one multi-cycle GCD engine between NUM_REQ requesters.
- Accepts operand pairs over a valid/ready handshake and issues a one-cycle start pulse to the engine.
- Waits for the engine's done, then returns the result tagged with the requester index.
- Sits between the client blocks and the gcd_top datapath, adding start/done sequencing, a zero-operand bypass and a timeout watchdog.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/gcd_scheduler.sv | 148 ++++++++++++++
 tb/tb_gcd_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD scheduler slice: FSM state encoding,
// default operand width and requester-index width.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_NUM_REQ = 4;
    localparam int ID_W            = $clog2(DEFAULT_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr,
// wrapping modulo N, so the last winner has lowest priority next time.
module rr_arbiter
    import gcd_pkg::*;
#(
    parameter int N  = DEFAULT_NUM_REQ,
    parameter int IW = ID_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] pos;

    always_comb begin
        // NOTE: every output gets a default before the scan so no path infers a latch.
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!valid && req[pos]) begin
                valid      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one multi-cycle GCD engine between NUM_REQ requesters: round-robin
// accept, start/done sequencing, zero-operand bypass and a timeout watchdog.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYC = 70000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       eng_start,
    output logic [WIDTH-1:0]           eng_a,
    output logic [WIDTH-1:0]           eng_b,
    input  logic                       eng_done,
    input  logic [WIDTH-1:0]           eng_result,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           resp_data,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       resp_err,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             grant_valid;
    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             zero_op;
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic [IW-1:0]    id_q;
    logic             err_q;
    logic [CW-1:0]    cnt;
    logic             timed_out;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .valid (grant_valid)
    );

    assign a_sel     = a_arr[grant_idx];
    assign b_sel     = b_arr[grant_idx];
    assign zero_op   = (a_sel == '0) || (b_sel == '0);
    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values whatever the block order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A handshake or engine start cannot complete while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        eng_start = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_ready = rst ? '0 : grant;
                    state_nxt = zero_op ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                eng_start = !rst;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_done || timed_out) state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IW'(NUM_REQ - 1);
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        a_q    <= a_sel;
                        b_q    <= b_sel;
                        id_q   <= grant_idx;
                        rr_ptr <= grant_idx;
                        data_q <= a_sel | b_sel;
                        err_q  <= 1'b0;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    // done has priority over a coincident timeout
                    if (eng_done) begin
                        data_q <= eng_result;
                        err_q  <= 1'b0;
                    end else if (timed_out) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign resp_valid = (state == RESP);
    assign resp_data  = data_q;
    assign resp_id    = id_q;
    assign resp_err   = err_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a 10-cycle GCD engine model.
module tb_gcd_scheduler;

    localparam int NR  = 4;
    localparam int W   = 16;
    localparam int TO  = 50;
    localparam int LAT = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [W-1:0]    tb_a [NR];
    logic [W-1:0]    tb_b [NR];
    logic [NR*W-1:0] req_a, req_b;
    logic [NR-1:0]   req_ready;
    logic            eng_start;
    logic [W-1:0]    eng_a, eng_b;
    logic            eng_done;
    logic [W-1:0]    eng_result;
    logic            resp_valid;
    logic            resp_ready;
    logic [W-1:0]    resp_data;
    logic [1:0]      resp_id;
    logic            resp_err;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;

    // engine model
    int           lat = 0;
    logic [W-1:0] ma, mb, model_result;
    logic         model_done = 1'b0;
    logic         manual_done = 1'b0;
    logic         eng_enable = 1'b1;

    always #5 clk = ~clk;

    assign req_a      = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
    assign req_b      = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};
    assign eng_done   = model_done | manual_done;
    assign eng_result = manual_done ? 16'hBEEF : model_result;

    gcd_scheduler #(
        .NUM_REQ     (NR),
        .WIDTH       (W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    always @(posedge clk) if (eng_start) start_cnt <= start_cnt + 1;

    always @(negedge clk) begin
        if (eng_start && eng_enable) begin
            lat        <= LAT;
            ma         <= eng_a;
            mb         <= eng_b;
            model_done <= 1'b0;
        end else if (lat > 1) begin
            lat        <= lat - 1;
            model_done <= 1'b0;
        end else if (lat == 1) begin
            lat          <= 0;
            model_done   <= 1'b1;
            model_result <= gcd_ref(ma, mb);
        end else begin
            model_done <= 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i] = 1'b1;
        tb_a[i] = a;
        tb_b[i] = b;
    endtask

    // Returns the ready vector seen (0 on budget expiry), positioned one cycle after acceptance.
    task automatic wait_accept(input int budget, output logic [NR-1:0] got);
        got = '0;
        for (int c = 0; c < budget; c++) begin
            if (req_ready != '0) begin
                got = req_ready;
                break;
            end
            step();
        end
        if (got != '0) begin
            @(negedge clk);
            req_valid = req_valid & ~got;
            #1;
        end
    endtask

    task automatic wait_resp(input int budget, output bit seen, output bit done_prev);
        seen = 1'b0;
        done_prev = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            done_prev = eng_done;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step();
        n_vec++;
        if ({busy, resp_valid, eng_start, resp_err, req_ready} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {busy, resp_valid, eng_start, resp_err, req_ready});
        end
        n_vec++;
        if ({resp_data, eng_a, eng_b} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0", {resp_data, eng_a, eng_b});
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [NR-1:0] got;
        bit seen, dp;
        step();
        set_req(0, 16'd20, 16'd30);
        #1;
        wait_accept(5, got);
        n_vec++;
        if (got !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b expected 0001", got); end
        n_vec++;
        if (eng_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b expected 1", eng_start); end
        n_vec++;
        if ({eng_a, eng_b} !== {16'd20, 16'd30}) begin
            n_err++;
            $display("FAIL single_operands: got %0d,%0d expected 20,30", eng_a, eng_b);
        end
        step();
        n_vec++;
        if (eng_start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse: got %b expected 0", eng_start); end
        wait_resp(40, seen, dp);
        n_vec++;
        if (!seen || !dp) begin n_err++; $display("FAIL single_resp_timing: seen %b done_prev %b expected 1 1", seen, dp); end
        n_vec++;
        if ({resp_data, resp_id, resp_err} !== {16'd10, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL single_resp: got data %0d id %0d err %b expected 10 0 0", resp_data, resp_id, resp_err);
        end
        step();
        n_vec++;
        if ({resp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single_drop: got %b expected 00", {resp_valid, busy}); end
    endtask

    task automatic test_second();
        logic [NR-1:0] got;
        bit seen, dp;
        set_req(1, 16'd10, 16'd2);
        #1;
        wait_accept(5, got);
        n_vec++;
        if (got !== 4'b0010) begin n_err++; $display("FAIL second_ready: got %b expected 0010", got); end
        wait_resp(40, seen, dp);
        n_vec++;
        if (!seen || {resp_data, resp_id, resp_err} !== {16'd2, 2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL second_resp: seen %b data %0d id %0d err %b expected 1 2 1 0", seen, resp_data, resp_id, resp_err);
        end
    endtask

    task automatic test_contention();
        logic [NR-1:0] got;
        bit seen, dp;
        logic [NR-1:0] exp_got  [5] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        logic [W-1:0]  exp_data [5] = '{16'd6, 16'd7, 16'd3, 16'd4, 16'd5};
        logic [1:0]    exp_id   [5] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
        step();
        rst = 1'b1;
        set_req(0, 16'd12, 16'd18);
        set_req(2, 16'd21, 16'd14);
        set_req(3, 16'd9, 16'd6);
        #1;
        n_vec++;
        if (req_ready !== 4'b0000) begin n_err++; $display("FAIL contention_ready_in_reset: got %b expected 0000", req_ready); end
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_accept(10, got);
            n_vec++;
            if (got !== exp_got[k]) begin
                n_err++;
                $display("FAIL contention_grant%0d: got %b expected %b", k, got, exp_got[k]);
            end
            if (k == 2) begin
                set_req(0, 16'd8, 16'd12);
                set_req(2, 16'd15, 16'd25);
            end
            wait_resp(40, seen, dp);
            n_vec++;
            if (!seen || {resp_data, resp_id} !== {exp_data[k], exp_id[k]}) begin
                n_err++;
                $display("FAIL contention_resp%0d: seen %b data %0d id %0d expected 1 %0d %0d",
                         k, seen, resp_data, resp_id, exp_data[k], exp_id[k]);
            end
        end
    endtask

    task automatic test_zero();
        logic [NR-1:0] got;
        int s0;
        step();
        s0 = start_cnt;
        set_req(1, 16'd0, 16'd7);
        #1;
        wait_accept(5, got);
        n_vec++;
        if (got !== 4'b0010) begin n_err++; $display("FAIL zero_ready: got %b expected 0010", got); end
        n_vec++;
        if ({resp_valid, resp_data, resp_id, resp_err} !== {1'b1, 16'd7, 2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL zero_resp: got valid %b data %0d id %0d err %b expected 1 7 1 0",
                     resp_valid, resp_data, resp_id, resp_err);
        end
        step();
        set_req(3, 16'd0, 16'd0);
        #1;
        wait_accept(5, got);
        n_vec++;
        if (got !== 4'b1000) begin n_err++; $display("FAIL zero00_ready: got %b expected 1000", got); end
        n_vec++;
        if ({resp_valid, resp_data, resp_id} !== {1'b1, 16'd0, 2'd3}) begin
            n_err++;
            $display("FAIL zero00_resp: got valid %b data %0d id %0d expected 1 0 3", resp_valid, resp_data, resp_id);
        end
        n_vec++;
        if (start_cnt !== s0) begin n_err++; $display("FAIL zero_no_start: got %0d starts expected %0d", start_cnt, s0); end
    endtask

    task automatic test_backpressure();
        logic [NR-1:0] got;
        bit seen, dp;
        step();
        resp_ready = 1'b0;
        set_req(0, 16'd0, 16'd5);
        set_req(2, 16'd4, 16'd6);
        #1;
        wait_accept(5, got);
        n_vec++;
        if (got !== 4'b0001) begin n_err++; $display("FAIL bp_ready: got %b expected 0001", got); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({resp_valid, resp_data, req_ready} !== {1'b1, 16'd5, 4'b0000}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got valid %b data %0d ready %b expected 1 5 0000", i, resp_valid, resp_data, req_ready);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        n_vec++;
        if ({resp_valid, req_ready} !== {1'b0, 4'b0100}) begin
            n_err++;
            $display("FAIL bp_release: got valid %b ready %b expected 0 0100", resp_valid, req_ready);
        end
        wait_accept(5, got);
        wait_resp(40, seen, dp);
        n_vec++;
        if (!seen || {resp_data, resp_id} !== {16'd2, 2'd2}) begin
            n_err++;
            $display("FAIL bp_next_resp: seen %b data %0d id %0d expected 1 2 2", seen, resp_data, resp_id);
        end
    endtask

    task automatic test_timeout();
        logic [NR-1:0] got;
        int  n;
        bit  any_v;
        step();
        eng_enable = 1'b0;
        set_req(1, 16'd9, 16'd12);
        #1;
        wait_accept(5, got);
        n_vec++;
        if ({got, eng_start} !== {4'b0010, 1'b1}) begin
            n_err++;
            $display("FAIL to_accept: got ready %b start %b expected 0010 1", got, eng_start);
        end
        n = 0;
        while (!resp_valid && n < 100) begin
            step();
            n++;
        end
        // 50 WAIT cycles after the start cycle, response visible on the next one
        n_vec++;
        if (n !== TO + 1) begin n_err++; $display("FAIL to_latency: got %0d cycles expected %0d", n, TO + 1); end
        n_vec++;
        if ({resp_err, resp_data, resp_id} !== {1'b1, 16'd0, 2'd1}) begin
            n_err++;
            $display("FAIL to_resp: got err %b data %0d id %0d expected 1 0 1", resp_err, resp_data, resp_id);
        end
        resp_ready  = 1'b0;
        manual_done = 1'b1;
        step();
        manual_done = 1'b0;
        n_vec++;
        if ({resp_valid, resp_err, resp_data} !== {1'b1, 1'b1, 16'd0}) begin
            n_err++;
            $display("FAIL to_late_done_resp: got valid %b err %b data %h expected 1 1 0", resp_valid, resp_err, resp_data);
        end
        resp_ready = 1'b1;
        step();
        manual_done = 1'b1;
        step();
        manual_done = 1'b0;
        any_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            any_v |= resp_valid | busy;
            step();
        end
        n_vec++;
        if (any_v !== 1'b0) begin n_err++; $display("FAIL to_late_done_idle: got activity %b expected 0", any_v); end
        eng_enable = 1'b1;
    endtask

    task automatic test_reset_wait();
        logic [NR-1:0] got;
        bit seen, dp, any_v;
        step();
        set_req(2, 16'd6, 16'd4);
        #1;
        wait_accept(5, got);
        n_vec++;
        if ({got, eng_start} !== {4'b0100, 1'b1}) begin
            n_err++;
            $display("FAIL rw_accept: got ready %b start %b expected 0100 1", got, eng_start);
        end
        repeat (3) step();
        rst = 1'b1;
        step();
        n_vec++;
        if ({busy, resp_valid, eng_a} !== {1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL rw_reset: got busy %b valid %b eng_a %0d expected 0 0 0", busy, resp_valid, eng_a);
        end
        rst = 1'b0;
        any_v = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            any_v |= resp_valid | busy;
        end
        n_vec++;
        if (any_v !== 1'b0) begin n_err++; $display("FAIL rw_silent: got activity %b expected 0", any_v); end
        set_req(1, 16'd10, 16'd4);
        set_req(3, 16'd0, 16'd9);
        #1;
        wait_accept(5, got);
        n_vec++;
        if (got !== 4'b0010) begin n_err++; $display("FAIL rw_ptr_restart: got %b expected 0010", got); end
        wait_resp(40, seen, dp);
        n_vec++;
        if (!seen || {resp_data, resp_id, resp_err} !== {16'd2, 2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL rw_resp: seen %b data %0d id %0d err %b expected 1 2 1 0", seen, resp_data, resp_id, resp_err);
        end
        wait_accept(5, got);
        n_vec++;
        if ({got, resp_valid, resp_data, resp_id} !== {4'b1000, 1'b1, 16'd9, 2'd3}) begin
            n_err++;
            $display("FAIL rw_next: got ready %b valid %b data %0d id %0d expected 1000 1 9 3", got, resp_valid, resp_data, resp_id);
        end
        step();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            tb_a[i] = '0;
            tb_b[i] = '0;
        end
        test_reset();
        test_single();
        test_second();
        test_contention();
        test_zero();
        test_backpressure();
        test_timeout();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
